// File: rtl/button_encoder_pkg.sv
// Shared encodings for the button encoder: FSM states and colour codes.
package button_encoder_pkg;

  typedef enum logic [1:0] {
    ENC_IDLE_S    = 2'd0,
    ENC_PRESS_S   = 2'd1,
    ENC_RELEASE_S = 2'd2
  } enc_state_e;

  localparam logic [1:0] COLOR_0 = 2'd0;
  localparam logic [1:0] COLOR_1 = 2'd1;
  localparam logic [1:0] COLOR_2 = 2'd2;
  localparam logic [1:0] COLOR_3 = 2'd3;

  // Only called with a one-hot argument; anything else maps to COLOR_0.
  function automatic logic [1:0] btn_code(input logic [3:0] v);
    logic [1:0] c;
    case (v)
      4'b0010: c = COLOR_1;
      4'b0100: c = COLOR_2;
      4'b1000: c = COLOR_3;
      default: c = COLOR_0;
    endcase
    return c;
  endfunction

  function automatic logic btn_multi(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/button_encoder_debounce.sv
// Single-bit debouncer: a new synced level must persist DB_CYCLES cycles
// before it is accepted onto Q.
module button_encoder_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic D_SYNC,
  output logic Q
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (D_SYNC == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = D_SYNC;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign Q = stable_q;

endmodule

// File: rtl/button_encoder.sv
// Player input front end: synchronize, debounce and encode four colour buttons
// plus a start button for the game controller.
module button_encoder
  import button_encoder_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  input  logic       START_BTN,
  output logic [1:0] IN,
  output logic       IN_VALID,
  output logic       START_GAME,
  output logic       MULTI_ERR
);

  logic [4:0] raw, sync1_q, sync2_q, db;

  assign raw = {START_BTN, BTN};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_db
    button_encoder_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .D_SYNC (sync2_q[i]),
      .Q      (db[i])
    );
  end

  enc_state_e state_q, state_d;
  logic [1:0] in_q, in_d;
  logic       in_valid_q, in_valid_d;
  logic       multi_err_d, multi_err_q;
  logic       start_q;

  always_comb begin
    state_d     = state_q;
    in_d        = in_q;
    in_valid_d  = in_valid_q;
    multi_err_d = 1'b0;
    case (state_q)
      ENC_IDLE_S: begin
        if (db[3:0] != 4'd0) begin
          if (btn_multi(db[3:0])) begin
            multi_err_d = 1'b1;
            in_valid_d  = 1'b0;
            state_d     = ENC_RELEASE_S;
          end else begin
            in_d       = btn_code(db[3:0]);
            in_valid_d = 1'b1;
            state_d    = ENC_PRESS_S;
          end
        end
      end
      ENC_PRESS_S: begin
        // Extra buttons are ignored; only the latched one ends the press.
        if (!db[in_q]) begin
          in_valid_d = 1'b0;
          state_d    = ENC_RELEASE_S;
        end else begin
          in_valid_d = 1'b1;
        end
      end
      ENC_RELEASE_S: begin
        in_valid_d = 1'b0;
        if (db[3:0] == 4'd0) state_d = ENC_IDLE_S;
      end
      default: begin
        in_valid_d = 1'b0;
        state_d    = ENC_IDLE_S;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ENC_IDLE_S;
      in_q        <= COLOR_0;
      in_valid_q  <= 1'b0;
      multi_err_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_q        <= in_d;
      in_valid_q  <= in_valid_d;
      multi_err_q <= multi_err_d;
      start_q     <= db[4];
    end
  end

  assign IN         = in_q;
  assign IN_VALID   = in_valid_q;
  assign START_GAME = start_q;
  assign MULTI_ERR  = multi_err_q;

endmodule
